// File: rtl/add_serial_n.sv
// add_serial_n: switch-fed bit-serial adder/subtractor with debounced keys,
// operand/result/accumulator registers and registered 7-segment readouts.
module add_serial_n #(
    parameter  int WIDTH        = 8,
    parameter  int DEBOUNCE_CYC = 50000,
    localparam int NDIG         = (WIDTH + 3) / 4
) (
    input  logic                iCLK_50,
    input  logic                iRST_N,
    input  logic [WIDTH-1:0]    iSW,
    input  logic                iKEY_LOAD_A,
    input  logic                iKEY_LOAD_B,
    input  logic                iKEY_EXEC,
    input  logic [1:0]          iMODE,
    output logic [WIDTH-1:0]    oA,
    output logic [WIDTH-1:0]    oB,
    output logic [WIDTH-1:0]    oRESULT,
    output logic                oCARRY,
    output logic                oOVF,
    output logic                oBUSY,
    output logic                oVALID,
    output logic [7*NDIG-1:0]   oHEX_A,
    output logic [7*NDIG-1:0]   oHEX_B,
    output logic [7*NDIG-1:0]   oHEX_R,
    output logic [6:0]          oHEX_C
);

    localparam int DCW = $clog2(DEBOUNCE_CYC + 1);
    localparam int BCW = $clog2(WIDTH + 1);
    localparam logic [6:0] SEG_ZERO = 7'b1000000;
    localparam logic [6:0] SEG_ONE  = 7'b1111001;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    // Key index: 0 = LOAD_A, 1 = LOAD_B, 2 = EXEC
    logic [2:0]       w_key_raw;
    logic [2:0]       r_sync1;
    logic [2:0]       r_sync2;
    logic [2:0]       r_db;
    logic [DCW-1:0]   r_dcnt [3];
    logic [2:0]       w_flip;
    logic [2:0]       w_press;
    logic             w_ld_a;
    logic             w_ld_b;
    logic             w_exec;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic             r_ovf;
    logic             r_valid;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_sum;
    logic             r_c;
    logic [BCW-1:0]   r_bitcnt;

    logic [WIDTH-1:0] w_a_eff;
    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH-1:0] w_x_init;
    logic [WIDTH-1:0] w_y_init;
    logic             w_sum_bit;
    logic             w_cout;
    logic [WIDTH-1:0] w_sum_shift;
    logic             w_last;

    logic [4*NDIG-1:0] w_pad_a;
    logic [4*NDIG-1:0] w_pad_b;
    logic [4*NDIG-1:0] w_pad_r;
    logic [7*NDIG-1:0] w_hex_a_nxt;
    logic [7*NDIG-1:0] w_hex_b_nxt;
    logic [7*NDIG-1:0] w_hex_r_nxt;
    logic [6:0]        w_hex_c_nxt;
    logic [7*NDIG-1:0] r_hex_a;
    logic [7*NDIG-1:0] r_hex_b;
    logic [7*NDIG-1:0] r_hex_r;
    logic [6:0]        r_hex_c;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign w_key_raw = {iKEY_EXEC, iKEY_LOAD_B, iKEY_LOAD_A};

    // Debounce qualification: a key flips when the synced level has differed for DEBOUNCE_CYC samples
    always_comb begin
        w_flip  = '0;
        w_press = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            w_flip[i]  = (r_sync2[i] != r_db[i]) && (r_dcnt[i] == DCW'(DEBOUNCE_CYC - 1));
            w_press[i] = w_flip[i] & r_db[i];
        end
    end

    assign w_ld_a = w_press[0];
    assign w_ld_b = w_press[1];
    assign w_exec = w_press[2];

    // Key synchronisers, stability counters and debounced levels
    always_ff @(posedge iCLK_50) begin
        if (!iRST_N) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
            r_db    <= '1;
            for (int unsigned i = 0; i < 3; i++) begin
                r_dcnt[i] <= '0;
            end
        end else begin
            r_sync1 <= w_key_raw;
            r_sync2 <= r_sync1;
            for (int unsigned i = 0; i < 3; i++) begin
                if (r_sync2[i] == r_db[i]) begin
                    r_dcnt[i] <= '0;
                end else if (w_flip[i]) begin
                    r_db[i]   <= r_sync2[i];
                    r_dcnt[i] <= '0;
                end else begin
                    r_dcnt[i] <= r_dcnt[i] + 1'b1;
                end
            end
        end
    end

    // Operand forwarding: a load coinciding with exec feeds the freshly loaded value
    assign w_a_eff  = w_ld_a ? iSW : r_a;
    assign w_b_eff  = w_ld_b ? iSW : r_b;
    assign w_x_init = (iMODE == 2'b10) ? r_result : w_a_eff;
    assign w_y_init = (iMODE == 2'b01) ? ~w_b_eff : w_b_eff;

    // One full-adder slice per cycle on the shifter LSBs
    assign w_sum_bit   = r_x[0] ^ r_y[0] ^ r_c;
    assign w_cout      = (r_x[0] & r_y[0]) | (r_c & (r_x[0] ^ r_y[0]));
    assign w_sum_shift = {w_sum_bit, r_sum[WIDTH-1:1]};
    assign w_last      = (r_bitcnt == BCW'(WIDTH - 1));

    // FSM state register
    always_ff @(posedge iCLK_50) begin
        if (!iRST_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state: clear (mode 11) completes in IDLE without entering RUN
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_exec && (iMODE != 2'b11)) w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand registers, serial datapath and result/flag update
    always_ff @(posedge iCLK_50) begin
        if (!iRST_N) begin
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_ovf    <= 1'b0;
            r_valid  <= 1'b0;
            r_x      <= '0;
            r_y      <= '0;
            r_sum    <= '0;
            r_c      <= 1'b0;
            r_bitcnt <= '0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_ld_a) r_a <= iSW;
                    if (w_ld_b) r_b <= iSW;
                    if (w_exec) begin
                        if (iMODE == 2'b11) begin
                            r_result <= '0;
                            r_carry  <= 1'b0;
                            r_ovf    <= 1'b0;
                            r_valid  <= 1'b1;
                        end else begin
                            r_x      <= w_x_init;
                            r_y      <= w_y_init;
                            r_c      <= (iMODE == 2'b01);
                            r_sum    <= '0;
                            r_bitcnt <= '0;
                        end
                    end
                end
                S_RUN: begin
                    r_x      <= r_x >> 1;
                    r_y      <= r_y >> 1;
                    r_sum    <= w_sum_shift;
                    r_c      <= w_cout;
                    r_bitcnt <= r_bitcnt + 1'b1;
                    // Result is committed on the last bit so it is visible during DONE
                    if (w_last) begin
                        r_result <= w_sum_shift;
                        r_carry  <= w_cout;
                        r_ovf    <= r_c ^ w_cout;
                        r_valid  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Segment patterns per nibble, top digit zero-filled above WIDTH
    always_comb begin
        w_pad_a = '0;
        w_pad_b = '0;
        w_pad_r = '0;
        w_pad_a[WIDTH-1:0] = r_a;
        w_pad_b[WIDTH-1:0] = r_b;
        w_pad_r[WIDTH-1:0] = r_result;
        w_hex_a_nxt = '0;
        w_hex_b_nxt = '0;
        w_hex_r_nxt = '0;
        for (int unsigned i = 0; i < NDIG; i++) begin
            w_hex_a_nxt[7*i +: 7] = seg7(w_pad_a[4*i +: 4]);
            w_hex_b_nxt[7*i +: 7] = seg7(w_pad_b[4*i +: 4]);
            w_hex_r_nxt[7*i +: 7] = seg7(w_pad_r[4*i +: 4]);
        end
        w_hex_c_nxt = r_carry ? SEG_ONE : SEG_ZERO;
    end

    // Registered display drivers
    always_ff @(posedge iCLK_50) begin
        if (!iRST_N) begin
            r_hex_a <= {NDIG{SEG_ZERO}};
            r_hex_b <= {NDIG{SEG_ZERO}};
            r_hex_r <= {NDIG{SEG_ZERO}};
            r_hex_c <= SEG_ZERO;
        end else begin
            r_hex_a <= w_hex_a_nxt;
            r_hex_b <= w_hex_b_nxt;
            r_hex_r <= w_hex_r_nxt;
            r_hex_c <= w_hex_c_nxt;
        end
    end

    assign oA      = r_a;
    assign oB      = r_b;
    assign oRESULT = r_result;
    assign oCARRY  = r_carry;
    assign oOVF    = r_ovf;
    assign oBUSY   = (r_state == S_RUN);
    assign oVALID  = r_valid;
    assign oHEX_A  = r_hex_a;
    assign oHEX_B  = r_hex_b;
    assign oHEX_R  = r_hex_r;
    assign oHEX_C  = r_hex_c;

endmodule

// File: doc/add_serial_n.md
# add_serial_n

Parametrised successor of the 4-bit board adder. It takes a WIDTH-bit sum and difference from switch operands and computes them with a bit-serial ripple adder, one bit per clock. The block latches operands on debounced push-button presses, keeps an accumulator, and drives registered active-low 7-segment digits for A, B, result and carry. It sits directly under the DE2-70 top level and is fed by raw switches and keys.

## Interface
- WIDTH, 8: operand/result width; NDIG = (WIDTH+3)/4 derived digits per value.
- DEBOUNCE_CYC, 50000: cycles a synchronised key must stay stable before a press is accepted (1 ms at 50 MHz).
- iCLK_50  in  1  system clock, all logic rising-edge.
- iRST_N  in  1  synchronous active-low reset.
- iSW  in  WIDTH  operand data.
- iKEY_LOAD_A  in  1  raw active-low button, loads A.
- iKEY_LOAD_B  in  1  raw active-low button, loads B.
- iKEY_EXEC  in  1  raw active-low button, starts operation.
- iMODE  in  2  00 R=A+B, 01 R=A−B, 10 R=R+B (accumulate), 11 R=0 (clear).
- oA, oB  out  WIDTH  operand registers.
- oRESULT  out  WIDTH  result register.
- oCARRY  out  1  carry out (sub: 1 = no borrow).
- oOVF  out  1  two's-complement overflow.
- oBUSY  out  1  serial operation in progress.
- oVALID  out  1  one-cycle pulse when oRESULT/oCARRY/oOVF update.
- oHEX_A, oHEX_B, oHEX_R  out  7*NDIG  active-low segments, digit i at [7i+6:7i] = nibble i, gfedcba order.
- oHEX_C  out  7  active-low digit showing oCARRY as 0/1.

## Operation
- Each key uses a 2-flop synchroniser and a counter. The debounced level changes only after DEBOUNCE_CYC consecutive equal samples. A 1→0 debounced transition gives a one-cycle press pulse.
- IDLE: a LOAD_A/LOAD_B pulse copies iSW into oA/oB. Simultaneous pulses load both. Loads and exec are ignored outside IDLE.
- IDLE + exec pulse, mode 00/01/10: operand X (oA, or oRESULT for mode 10) and Y (oB, inverted for mode 01) go into shift registers, carry-in = 1 for sub, else 0. Go to RUN.
- If the exec pulse coincides with a load pulse, the load happens first and exec uses the new value.
- RUN: each cycle adds the LSBs plus the carry flop, shifts the sum bit into the result shifter MSB and increments the bit counter. After WIDTH bits go to DONE.
- DONE (1 cycle): write oRESULT, oCARRY = final carry, oOVF = carry into MSB XOR carry out; pulse oVALID; return to IDLE.
- Mode 11 exec: oRESULT=0, oCARRY=0, oOVF=0 and oVALID pulse on the next cycle, with no RUN.
- Arithmetic is modulo 2^WIDTH. Nibbles above WIDTH in the top digit are zero-filled.
- Font, active-low gfedcba: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.

## Timing
- Reset (iRST_N=0 at a clock edge) clears oA, oB, oRESULT, oCARRY, oOVF, oBUSY, oVALID, the shifters, the debounce state and the FSM (→IDLE).
- After reset, all hex digits read 1000000 ("0") from the following cycle.
- Reset during RUN aborts the operation with no oVALID pulse.
- Key to press pulse: 2 sync cycles + DEBOUNCE_CYC cycles.
- Load pulse at cycle t: oA/oB valid at t+1, hex at t+2.
- Exec pulse at t: oBUSY=1 for cycles t+1 … t+WIDTH. oVALID=1 and new result at t+WIDTH+1 (DONE, oBUSY=0 there). Hex at t+WIDTH+2.
- Mode 11: oVALID and result at t+1.
- oRESULT, oCARRY and oOVF hold between operations.

## Test plan
- WIDTH=8, DEBOUNCE_CYC=4: load A=0x3C, B=0xC5, mode 00, exec → oRESULT=0x01, oCARRY=1, oOVF=0; oVALID exactly 9 cycles after exec pulse; oHEX_R = {1000000, 1111001}.
- Mode 01: 0x10−0x20 → 0xF0, oCARRY=0, oOVF=0; 0x80−0x01 → 0x7F, oCARRY=1, oOVF=1.
- Mode 11 then mode 10 with B=0x90, exec ×3 → 0x90 (C=0), 0x20 (C=1, V=1), 0xB0 (C=0, V=0).
- LOAD_A key low for 3 cycles, then bouncing 0/1 every 2 cycles for 20 cycles → no load. A clean low held ≥6 cycles → exactly one load.
- Exec during RUN, plus LOAD_B pulse during RUN → both ignored; one oVALID; oB unchanged.
- iRST_N low at the 3rd RUN cycle → next cycle all outputs zero, oBUSY=0, no oVALID; a fresh exec then works normally.
